// File: rtl/pwm_sample_feeder_if.sv
// Sample memory read bus between the PWM sample feeder and its BRAM/ROM.
// Address is registered by the feeder; data returns one clock later.
interface pwm_sample_feeder_if #(
    parameter int ADDR_W = 16
) ();
    logic [ADDR_W-1:0] mem_addr_out;
    logic [7:0]        mem_data_in;

    modport master (
        output mem_addr_out,
        input  mem_data_in
    );

    modport slave (
        input  mem_addr_out,
        output mem_data_in
    );
endinterface

// File: rtl/pwm_sample_feeder.sv
// Reads 8-bit clip samples from memory and presents one per CLK_DIV clocks
// to the PWM stage, with start/stop, looping and midscale silence when idle.
module pwm_sample_feeder #(
    parameter int CLK_DIV   = 2268,
    parameter int ADDR_W    = 16,
    parameter int LAST_ADDR = 49999
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                play_in,
    input  logic                loop_in,
    pwm_sample_feeder_if.master mem,
    output logic [7:0]          x_out,
    output logic                sample_strobe_out,
    output logic                busy_out,
    output logic                done_out
);

    localparam int                DIV_W     = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]  DIV_MAX   = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_CAP   = DIV_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LAST_ADDR);
    localparam logic [7:0]        MIDSCALE  = 8'h80;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        buf_q, buf_d;
    logic [7:0]        x_q, x_d;
    logic              strobe_q, strobe_d;
    logic              done_q, done_d;
    logic              play_q;
    logic              start;
    logic              tick;

    assign start = play_in & ~play_q;
    assign tick  = (div_q == DIV_MAX);

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        addr_d   = addr_q;
        buf_d    = buf_q;
        x_d      = x_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                div_d  = '0;
                addr_d = '0;
                x_d    = MIDSCALE;
                if (start) state_d = PLAY;
            end
            PLAY, DRAIN: begin
                // Dropping play_in wins over any tick in the same cycle
                if (!play_in) begin
                    state_d = IDLE;
                    div_d   = '0;
                    addr_d  = '0;
                    x_d     = MIDSCALE;
                end else begin
                    div_d = tick ? '0 : div_q + DIV_W'(1);
                    if (state_q == PLAY) begin
                        if (div_q == DIV_CAP) buf_d = mem.mem_data_in;
                        if (tick) begin
                            x_d      = buf_q;
                            strobe_d = 1'b1;
                            if (addr_q != ADDR_LAST) addr_d = addr_q + ADDR_W'(1);
                            else if (loop_in)        addr_d = '0;
                            else                     state_d = DRAIN;
                        end
                    end else if (tick) begin
                        x_d     = MIDSCALE;
                        done_d  = 1'b1;
                        addr_d  = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            div_q    <= '0;
            addr_q   <= '0;
            buf_q    <= '0;
            x_q      <= MIDSCALE;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            play_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            addr_q   <= addr_d;
            buf_q    <= buf_d;
            x_q      <= x_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            play_q   <= play_in;
        end
    end

    assign mem.mem_addr_out  = addr_q;
    assign x_out             = x_q;
    assign sample_strobe_out = strobe_q;
    assign done_out          = done_q;
    assign busy_out          = (state_q != IDLE);

endmodule

// File: tb/tb_pwm_sample_feeder.sv
// Scoreboard bench for pwm_sample_feeder: a clip-level model predicts every
// sample/done event; a negedge monitor pops and compares as the DUT emits them.
module tb_pwm_sample_feeder;
    localparam int CLK_DIV   = 4;
    localparam int ADDR_W    = 4;
    localparam int LAST_ADDR = 3;
    localparam int N         = LAST_ADDR + 1;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       play = 1'b0;
    logic       loop = 1'b0;
    logic [7:0] x;
    logic       strobe;
    logic       busy;
    logic       done;

    pwm_sample_feeder_if #(.ADDR_W(ADDR_W)) mif ();

    pwm_sample_feeder #(
        .CLK_DIV  (CLK_DIV),
        .ADDR_W   (ADDR_W),
        .LAST_ADDR(LAST_ADDR)
    ) dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .play_in          (play),
        .loop_in          (loop),
        .mem              (mif),
        .x_out            (x),
        .sample_strobe_out(strobe),
        .busy_out         (busy),
        .done_out         (done)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [16];

    always @(posedge clk) mif.mem_data_in <= mem[mif.mem_addr_out];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] x;
        bit         done;
    } ev_t;

    ev_t q[$];
    int  tests = 0;
    int  fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe/done must match the head of the expected queue
    always @(negedge clk) begin : monitor
        ev_t e;
        if (!rst) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                chk("missed_event_cycle", cyc, q[0].cyc);
                void'(q.pop_front());
            end
            if (strobe || done) begin
                if (q.size() == 0) begin
                    chk("unexpected_event", {30'd0, strobe, done}, 0);
                end else begin
                    e = q.pop_front();
                    chk("event_cycle", cyc, e.cyc);
                    chk("event_x", x, e.x);
                    chk("event_done", done, e.done);
                    chk("event_strobe", strobe, !e.done);
                end
            end
        end
    end

    // Raise play for d clocks; model predicts the clip events from the
    // start edge t: sample k lands at t+k*CLK_DIV, stop edge s cuts it off.
    task automatic run(input bit lp, input int d);
        int t, s, e;
        @(negedge clk);
        play = 1'b1;
        loop = lp;
        t = cyc + 1;
        s = t + d;
        for (int k = 1; k < 1000; k++) begin
            e = t + k * CLK_DIV;
            if (e >= s) break;
            if (!lp && k == N + 1) begin
                q.push_back('{e, 8'h80, 1'b1});
                break;
            end
            q.push_back('{e, mem[(k - 1) % N], 1'b0});
        end
        @(negedge clk);
        chk("busy_after_start", busy, 1);
        repeat (d - 1) @(negedge clk);
        play = 1'b0;
        @(negedge clk);
        chk("busy_after_end", busy, 0);
        chk("x_idle_after_end", x, 8'h80);
        chk("addr_idle_after_end", mif.mem_addr_out, 0);
    endtask

    initial begin : stim
        int t;
        for (int i = 0; i < 16; i++) mem[i] = 8'(i * 16 + 1);
        repeat (3) @(negedge clk);
        chk("reset_x", x, 8'h80);
        chk("reset_busy", busy, 0);
        rst = 1'b0;

        repeat (10) begin
            @(negedge clk);
            chk("idle_x", x, 8'h80);
            chk("idle_addr", mif.mem_addr_out, 0);
            chk("idle_strobe", strobe, 0);
            chk("idle_done", done, 0);
            chk("idle_busy", busy, 0);
        end

        run(1'b0, 30);
        run(1'b1, 30);
        run(1'b0, 9);
        run(1'b0, 12);
        run(1'b0, 45);
        run(1'b0, 22);
        run(1'b0, 21);
        run(1'b0, 20);

        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run(1'($urandom_range(0, 1)), $urandom_range(1, 40));
        end

        for (int i = 0; i < 16; i++) mem[i] = 8'(i * 16 + 1);
        @(negedge clk);
        play = 1'b1;
        loop = 1'b0;
        t = cyc + 1;
        q.push_back('{t + CLK_DIV, 8'h01, 1'b0});
        q.push_back('{t + 2 * CLK_DIV, 8'h11, 1'b0});
        repeat (9) @(negedge clk);
        chk("mid_play_x", x, 8'h11);
        chk("mid_play_busy", busy, 1);
        @(posedge clk);
        #2;
        rst  = 1'b1;
        play = 1'b0;
        #1;
        chk("async_rst_x", x, 8'h80);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_addr", mif.mem_addr_out, 0);
        chk("async_rst_strobe", strobe, 0);
        chk("pending_before_rst", q.size(), 0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("post_rst_busy", busy, 0);
            chk("post_rst_x", x, 8'h80);
        end
        run(1'b0, 25);

        repeat (5) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
